// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle 64-bit core: opcodes, FSM states,
// instruction field positions and the immediate sign-extension helper.
package cpu_pkg;

  localparam int XLEN     = 64;
  localparam int NUM_REGS = 16;

  localparam logic [5:0] OP_HLT  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd6;
  localparam logic [5:0] OP_LD   = 6'd7;
  localparam logic [5:0] OP_ST   = 6'd8;
  localparam logic [5:0] OP_BEQ  = 6'd9;
  localparam logic [5:0] OP_JAL  = 6'd10;
  localparam logic [5:0] OP_IRET = 6'd11;
  localparam logic [5:0] OP_LUI  = 6'd12;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 14;
  localparam int IMM_MSB = 13;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_EXEC       = 3'd2,
    S_MEM_WAIT   = 3'd3,
    S_HALT       = 3'd4
  } state_e;

  function automatic logic [XLEN-1:0] sx_imm(input logic [31:0] ir);
    return {{(XLEN-IMM_MSB-1){ir[IMM_MSB]}}, ir[IMM_MSB:0]};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 16 x 64-bit register file: two combinational read ports, one write port,
// r0 reads as zero and ignores writes.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      rs1_addr_i,
  input  logic [3:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            we_i,
  input  logic [3:0]      wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 4'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 4'd0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 4'd0) ? '0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/cpu_core.sv
// Multicycle core: FETCH -> FETCH_WAIT -> EXEC [-> MEM_WAIT] with a
// request/complete RAM handshake and a level-sensitive interrupt taken in FETCH.
// Bus handshake: ram_txs rises with exactly one of ram_re/ram_we; txs, the
// qualifier, ram_addr and ram_wd hold until ram_txe is sampled, then all drop.
module cpu_core
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] INT_BASE = 64'h100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ram_txs,
  input  logic        ram_txe,
  output logic        ram_re,
  output logic        ram_we,
  output logic [63:0] ram_addr,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_out,
  input  logic        int_i,
  input  logic [7:0]  int_dev_id,
  output logic        hlt,
  output logic [2:0]  dbg_state_o
);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d, epc_q, epc_d, addr_q, addr_d;
  logic [31:0] ir_q, ir_d, wd_q, wd_d;
  logic        ie_q, ie_d, txs_q, txs_d, re_q, re_d, we_q, we_d, hlt_q, hlt_d;

  logic        rf_we;
  logic [63:0] rf_wd, rs1_val, rs2_val, simm;
  logic [5:0]  op;

  assign op   = ir_q[OP_MSB:OP_LSB];
  assign simm = sx_imm(ir_q);

  cpu_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr_i (ir_q[RS1_MSB:RS1_LSB]),
    .rs2_addr_i (ir_q[RS2_MSB:RS2_LSB]),
    .rs1_data_o (rs1_val),
    .rs2_data_o (rs2_val),
    .we_i       (rf_we),
    .wa_i       (ir_q[RD_MSB:RD_LSB]),
    .wd_i       (rf_wd)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    ie_d    = ie_q;
    ir_d    = ir_q;
    txs_d   = txs_q;
    re_d    = re_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    hlt_d   = hlt_q;
    rf_we   = 1'b0;
    rf_wd   = '0;
    case (state_q)
      S_FETCH: begin
        if (int_i && ie_q) begin
          epc_d = pc_q;
          ie_d  = 1'b0;
          pc_d  = INT_BASE + {54'd0, int_dev_id, 2'b00};
        end else begin
          txs_d   = 1'b1;
          re_d    = 1'b1;
          addr_d  = pc_q;
          state_d = S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: begin
        if (ram_txe) begin
          ir_d    = ram_out;
          txs_d   = 1'b0;
          re_d    = 1'b0;
          addr_d  = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_d    = pc_q + 64'd4;
        state_d = S_FETCH;
        case (op)
          OP_ADD:  begin rf_we = 1'b1; rf_wd = rs1_val + rs2_val; end
          OP_SUB:  begin rf_we = 1'b1; rf_wd = rs1_val - rs2_val; end
          OP_AND:  begin rf_we = 1'b1; rf_wd = rs1_val & rs2_val; end
          OP_OR:   begin rf_we = 1'b1; rf_wd = rs1_val | rs2_val; end
          OP_XOR:  begin rf_we = 1'b1; rf_wd = rs1_val ^ rs2_val; end
          OP_ADDI: begin rf_we = 1'b1; rf_wd = rs1_val + simm; end
          OP_LUI:  begin rf_we = 1'b1; rf_wd = simm << 18; end
          OP_LD: begin
            txs_d   = 1'b1;
            re_d    = 1'b1;
            addr_d  = rs1_val + simm;
            state_d = S_MEM_WAIT;
          end
          OP_ST: begin
            txs_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = rs1_val + simm;
            wd_d    = rs2_val[31:0];
            state_d = S_MEM_WAIT;
          end
          OP_BEQ: begin
            if (rs1_val == rs2_val) pc_d = pc_q + (simm << 2);
          end
          OP_JAL: begin
            rf_we = 1'b1;
            rf_wd = pc_q + 64'd4;
            pc_d  = rs1_val + simm;
          end
          OP_IRET: begin
            pc_d = epc_q;
            ie_d = 1'b1;
          end
          default: begin
            // HLT and every undefined opcode stop the core.
            hlt_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_MEM_WAIT: begin
        if (ram_txe) begin
          if (re_q) begin
            rf_we = 1'b1;
            rf_wd = {32'd0, ram_out};
          end
          txs_d   = 1'b0;
          re_d    = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wd_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_HALT: hlt_d = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      ie_q    <= 1'b1;
      ir_q    <= '0;
      txs_q   <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      ie_q    <= ie_d;
      ir_q    <= ir_d;
      txs_q   <= txs_d;
      re_q    <= re_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      hlt_q   <= hlt_d;
    end
  end

  assign ram_txs     = txs_q;
  assign ram_re      = re_q;
  assign ram_we      = we_q;
  assign ram_addr    = addr_q;
  assign ram_wd      = wd_q;
  assign hlt         = hlt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: a behavioural RAM with random waits, an instruction-level
// interpreter as reference model, and directed plus random program scenarios.
module tb_cpu_core;
  import cpu_pkg::*;

  logic        clk, rst_n;
  logic        ram_txs, ram_txe, ram_re, ram_we;
  logic [63:0] ram_addr;
  logic [31:0] ram_wd, ram_out;
  logic        int_i;
  logic [7:0]  int_dev_id;
  logic        hlt;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int fixed_wait = 1;

  logic [31:0] mem   [1024];
  logic [31:0] m_mem [1024];
  logic [63:0] m_r   [16];
  logic [63:0] m_pc, m_epc;
  logic        m_ie;
  logic [63:0] exp_q [$];

  cpu_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ram_txs     (ram_txs),
    .ram_txe     (ram_txe),
    .ram_re      (ram_re),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wd      (ram_wd),
    .ram_out     (ram_out),
    .int_i       (int_i),
    .int_dev_id  (int_dev_id),
    .hlt         (hlt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- RAM slave model with handshake checks ----------------
  initial begin : ram_model
    int          left;
    bit          busy;
    logic [63:0] s_addr;
    logic        s_re, s_we;
    logic [31:0] s_wd;
    ram_txe = 1'b0; ram_out = '0; busy = 0; left = 0;
    s_addr = '0; s_re = 1'b0; s_we = 1'b0; s_wd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ram_txe = 1'b0;
        busy    = 0;
      end else if (ram_txe) begin
        ram_txe = 1'b0;
        n_cmp++;
        if ({ram_txs, ram_re, ram_we} !== 3'b000) begin
          n_err++;
          $display("FAIL bus_drop: txs/re/we=%b required 000", {ram_txs, ram_re, ram_we});
        end
      end else if (ram_txs) begin
        if (!busy) begin
          busy = 1;
          left = (fixed_wait > 0) ? fixed_wait : $urandom_range(1, 4);
          s_addr = ram_addr; s_re = ram_re; s_we = ram_we; s_wd = ram_wd;
          n_cmp++;
          if ((ram_re ^ ram_we) !== 1'b1) begin
            n_err++;
            $display("FAIL bus_qualifier: re=%b we=%b required exactly one", ram_re, ram_we);
          end
        end else begin
          n_cmp++;
          if ({ram_addr, ram_re, ram_we, ram_wd} !== {s_addr, s_re, s_we, s_wd}) begin
            n_err++;
            $display("FAIL bus_stable: addr=%h re=%b we=%b wd=%h required addr=%h re=%b we=%b wd=%h",
                     ram_addr, ram_re, ram_we, ram_wd, s_addr, s_re, s_we, s_wd);
          end
        end
        if (left > 1) begin
          left--;
        end else begin
          busy    = 0;
          ram_txe = 1'b1;
          if (s_we) mem[s_addr[11:2]] = s_wd;
          else      ram_out = mem[s_addr[11:2]];
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [31:0] v;
    v[31:26] = op[5:0];
    v[25:22] = rd[3:0];
    v[21:18] = rs1[3:0];
    v[17:14] = rs2[3:0];
    v[13:0]  = imm[13:0];
    return v;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      m_mem[i] = '0;
    end
  endtask

  task automatic put(input int w, input logic [31:0] v);
    mem[w] = v;
    m_mem[w] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (hlt === 1'b1) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_halt: hlt=%b after 5000 cycles, required 1", name, hlt);
    end
  endtask

  task automatic wait_txs(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ram_txs === 1'b1) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_txs: no request within 100 cycles, required one", name);
    end
  endtask

  // ---------------- reference model: instruction-level interpreter ----------------
  task automatic model_run(input bit irq_first, input logic [7:0] dev);
    logic [31:0] ir;
    logic [63:0] a, b, simm, ea, npc, wval;
    logic [3:0]  rd;
    bit          done, wen;
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = 64'h0; m_epc = 64'h0; m_ie = 1'b1;
    if (irq_first) begin
      m_epc = m_pc;
      m_ie  = 1'b0;
      m_pc  = 64'h100 + 64'(dev) * 4;
    end
    for (int s = 0; s < 4000; s++) begin
      ir   = m_mem[m_pc[11:2]];
      rd   = ir[25:22];
      a    = m_r[ir[21:18]];
      b    = m_r[ir[17:14]];
      simm = {{50{ir[13]}}, ir[13:0]};
      ea   = a + simm;
      npc  = m_pc + 64'd4;
      done = 0; wen = 0; wval = '0;
      case (ir[31:26])
        6'd1:  begin wen = 1; wval = a + b; end
        6'd2:  begin wen = 1; wval = a - b; end
        6'd3:  begin wen = 1; wval = a & b; end
        6'd4:  begin wen = 1; wval = a | b; end
        6'd5:  begin wen = 1; wval = a ^ b; end
        6'd6:  begin wen = 1; wval = a + simm; end
        6'd7:  begin wen = 1; wval = {32'd0, m_mem[ea[11:2]]}; end
        6'd8:  m_mem[ea[11:2]] = b[31:0];
        6'd9:  if (a == b) npc = m_pc + simm * 4;
        6'd10: begin wen = 1; wval = m_pc + 64'd4; npc = a + simm; end
        6'd11: begin npc = m_epc; m_ie = 1'b1; end
        6'd12: begin wen = 1; wval = simm * 64'd262144; end
        default: done = 1;
      endcase
      if (wen && rd != 4'd0) m_r[rd] = wval;
      m_pc = npc;
      if (done) break;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_model(input string name);
    logic [63:0] exp;
    int          diffs;
    for (int i = 0; i < 16; i++) exp_q.push_back(m_r[i]);
    for (int i = 0; i < 16; i++) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dut.u_regfile.regs_q[i] !== exp) begin
        n_err++;
        $display("FAIL %s_r%0d: got %h required %h", name, i, dut.u_regfile.regs_q[i], exp);
      end
    end
    n_cmp++;
    if ({dut.pc_q, dut.epc_q, dut.ie_q} !== {m_pc, m_epc, m_ie}) begin
      n_err++;
      $display("FAIL %s_pc_epc_ie: got %h %h %b required %h %h %b", name,
               dut.pc_q, dut.epc_q, dut.ie_q, m_pc, m_epc, m_ie);
    end
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== m_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin
      n_err++;
      $display("FAIL %s_mem: %0d words differ, required 0", name, diffs);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({ram_txs, hlt} !== 2'b01) begin
      n_err++;
      $display("FAIL %s_quiet: txs=%b hlt=%b required txs=0 hlt=1", name, ram_txs, hlt);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ram_txs, ram_re, ram_we, hlt} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: txs/re/we/hlt=%b required 0000", {ram_txs, ram_re, ram_we, hlt});
    end
    n_cmp++;
    if ({ram_addr, ram_wd} !== 96'd0) begin
      n_err++;
      $display("FAIL reset_bus: addr=%h wd=%h required 0", ram_addr, ram_wd);
    end
    n_cmp++;
    if ({dut.pc_q, dut.ie_q, dbg_state} !== {64'h0, 1'b1, 3'(S_FETCH)}) begin
      n_err++;
      $display("FAIL reset_arch: pc=%h ie=%b state=%0d required 0 1 FETCH", dut.pc_q, dut.ie_q, dbg_state);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (dut.u_regfile.regs_q[i] !== 64'd0) begin
        n_err++;
        $display("FAIL reset_r%0d: got %h required 0", i, dut.u_regfile.regs_q[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_basic();
    clear_mem();
    fixed_wait = 1;
    put(0, enc(6, 1, 0, 0, 5));
    put(1, enc(6, 2, 0, 0, 7));
    put(2, enc(1, 3, 1, 2, 0));
    put(3, enc(0, 0, 0, 0, 0));
    model_run(0, 8'd0);
    do_reset();
    wait_halt("alu");
    n_cmp++;
    if (dut.u_regfile.regs_q[3] !== 64'd12) begin
      n_err++;
      $display("FAIL alu_r3: got %h required 12", dut.u_regfile.regs_q[3]);
    end
    check_model("alu");
  endtask

  task automatic test_ld_st();
    clear_mem();
    fixed_wait = 2;
    put(0,  enc(10, 0, 0, 0, 64));
    put(16, enc(6, 1, 0, 0, 5));
    put(17, enc(6, 2, 0, 0, 7));
    put(18, enc(1, 3, 1, 2, 0));
    put(19, enc(8, 0, 0, 3, 16));
    put(20, enc(7, 4, 0, 0, 16));
    put(21, enc(0, 0, 0, 0, 0));
    model_run(0, 8'd0);
    do_reset();
    wait_halt("ldst");
    n_cmp++;
    if ({dut.u_regfile.regs_q[4], mem[4]} !== {64'd12, 32'h0000000C}) begin
      n_err++;
      $display("FAIL ldst_value: r4=%h mem16=%h required 12 0000000C", dut.u_regfile.regs_q[4], mem[4]);
    end
    check_model("ldst");
  endtask

  task automatic test_beq_loop();
    clear_mem();
    fixed_wait = 1;
    put(0, enc(6, 2, 0, 0, 3));
    put(1, enc(9, 0, 1, 2, 3));
    put(2, enc(6, 1, 1, 0, 1));
    put(3, enc(9, 0, 0, 0, 14'h3FFE));
    put(4, enc(0, 0, 0, 0, 0));
    model_run(0, 8'd0);
    do_reset();
    wait_halt("loop");
    n_cmp++;
    if ({dut.u_regfile.regs_q[1], dut.pc_q} !== {64'd3, 64'd20}) begin
      n_err++;
      $display("FAIL loop_exit: r1=%h pc=%h required 3 14", dut.u_regfile.regs_q[1], dut.pc_q);
    end
    check_model("loop");
  endtask

  task automatic test_wrap();
    clear_mem();
    fixed_wait = 3;
    put(0, enc(6, 1, 0, 0, 14'h3FFF));
    put(1, enc(6, 3, 0, 0, 1));
    put(2, enc(2, 2, 0, 3, 0));
    put(3, enc(0, 0, 0, 0, 0));
    model_run(0, 8'd0);
    do_reset();
    wait_halt("wrap");
    n_cmp++;
    if ({dut.u_regfile.regs_q[1], dut.u_regfile.regs_q[2]} !== {128{1'b1}}) begin
      n_err++;
      $display("FAIL wrap_value: r1=%h r2=%h required all ones", dut.u_regfile.regs_q[1], dut.u_regfile.regs_q[2]);
    end
    check_model("wrap");
  endtask

  task automatic test_interrupt();
    clear_mem();
    fixed_wait = 1;
    put(0,  enc(6, 1, 0, 0, 1));
    put(1,  enc(0, 0, 0, 0, 0));
    put(66, enc(6, 5, 0, 0, 9));
    put(67, enc(11, 0, 0, 0, 0));
    model_run(1, 8'd2);
    int_i = 1'b1;
    int_dev_id = 8'd2;
    do_reset();
    wait_txs("irq");
    n_cmp++;
    if ({ram_addr, dut.epc_q, dut.ie_q} !== {64'h108, 64'h0, 1'b0}) begin
      n_err++;
      $display("FAIL irq_entry: addr=%h epc=%h ie=%b required 108 0 0", ram_addr, dut.epc_q, dut.ie_q);
    end
    int_i = 1'b0;
    wait_halt("irq");
    check_model("irq");
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_mem();
    fixed_wait = 5;
    put(0, enc(6, 1, 0, 0, 3));
    put(1, enc(7, 2, 0, 0, 512));
    put(2, enc(0, 0, 0, 0, 0));
    put(128, $urandom);
    do_reset();
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ram_txs === 1'b1 && ram_addr === 64'd512) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL rstmid_ld: load request never seen, required one");
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ram_txs, ram_re, ram_we, hlt, ram_addr, ram_wd} !== 100'd0 || dbg_state !== 3'(S_FETCH)) begin
      n_err++;
      $display("FAIL rstmid_async: txs/re/we/hlt=%b addr=%h wd=%h state=%0d required all 0",
               {ram_txs, ram_re, ram_we, hlt}, ram_addr, ram_wd, dbg_state);
    end
    repeat (2) @(negedge clk);
    fixed_wait = 1;
    rst_n = 1'b1;
    wait_txs("rstmid");
    n_cmp++;
    if ({ram_addr, ram_re, ram_we} !== {64'h0, 2'b10}) begin
      n_err++;
      $display("FAIL rstmid_refetch: addr=%h re=%b we=%b required 0 1 0", ram_addr, ram_re, ram_we);
    end
    model_run(0, 8'd0);
    wait_halt("rstmid");
    check_model("rstmid");
  endtask

  task automatic test_back_to_back();
    int sel, op, rd, rs1, rs2, imm;
    for (int t = 0; t < 20; t++) begin
      clear_mem();
      fixed_wait = 0;
      for (int w = 128; w < 192; w++) put(w, $urandom);
      for (int k = 0; k < 12; k++) begin
        sel = $urandom_range(0, 9);
        rd  = $urandom_range(0, 15);
        rs1 = $urandom_range(0, 15);
        rs2 = $urandom_range(0, 15);
        imm = $urandom_range(0, 16383);
        op  = sel + 1;
        if (sel == 6 || sel == 7) begin
          op  = sel + 1;
          rs1 = 0;
          imm = 512 + 4 * $urandom_range(0, 63);
        end else if (sel == 8) begin
          op = 12;
        end else if (sel == 9) begin
          op  = 9;
          imm = $urandom_range(1, 3);
        end
        put(k, enc(op, rd, rs1, rs2, imm));
      end
      if ($urandom_range(0, 1) == 0) put(12, enc(0, 0, 0, 0, 0));
      else put(12, enc($urandom_range(13, 63), 1, 2, 3, 4));
      model_run(0, 8'd0);
      do_reset();
      wait_halt("rand");
      check_model("rand");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    int_i = 1'b0;
    int_dev_id = 8'd0;
    test_reset();
    test_alu_basic();
    test_ld_st();
    test_beq_loop();
    test_wrap();
    test_interrupt();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
